// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squashing,
// data-memory hold, register-file write-through bypass and a stall counter.
module id_ex_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [31:0]      id_rs1_data,
  input  logic [31:0]      id_rs2_data,
  input  logic [31:0]      id_imm,
  input  logic [3:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  input  logic             flush,
  input  logic             mem_hold,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [31:0]      ex_rs1_data,
  output logic [31:0]      ex_rs2_data,
  output logic [31:0]      ex_imm,
  output logic [3:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
  } ex_t;

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_BUBBLE
  } act_e;

  ex_t              r_ex;
  logic [CNT_W-1:0] r_cnt;
  ex_t              w_cap;
  act_e             w_act;
  logic             w_hz;

  assign w_hz = id_valid & r_ex.valid & r_ex.mem_read & (r_ex.rd != 5'd0) &
                ((id_uses_rs1 & (id_rs1 == r_ex.rd)) |
                 (id_uses_rs2 & (id_rs2 == r_ex.rd)));

  // Hold outranks flush outranks hazard; a flushed ID instruction cannot stall.
  always_comb begin
    w_act = ACT_CAPTURE;
    stall = 1'b0;
    if (mem_hold) begin
      w_act = ACT_HOLD;
      stall = 1'b1;
    end else if (flush) begin
      w_act = ACT_FLUSH;
    end else if (w_hz) begin
      w_act = ACT_BUBBLE;
      stall = 1'b1;
    end
  end

  always_comb begin
    w_cap            = '0;
    w_cap.valid      = id_valid;
    w_cap.pc         = id_pc;
    w_cap.rs1        = id_rs1;
    w_cap.rs2        = id_rs2;
    w_cap.rd         = id_rd;
    w_cap.rs1_data   = (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
    w_cap.rs2_data   = (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
    w_cap.imm        = id_imm;
    w_cap.alu_op     = id_alu_op;
    w_cap.alu_src    = id_alu_src;
    w_cap.mem_read   = id_mem_read;
    w_cap.mem_write  = id_mem_write;
    w_cap.reg_write  = id_reg_write;
    w_cap.mem_to_reg = id_mem_to_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= '0;
      r_cnt <= '0;
    end else begin
      case (w_act)
        ACT_HOLD:    r_ex <= r_ex;
        ACT_FLUSH:   r_ex <= '0;
        ACT_BUBBLE: begin
          r_ex <= '0;
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
        default:     r_ex <= w_cap;
      endcase
    end
  end

  assign ex_valid      = r_ex.valid;
  assign ex_pc         = r_ex.pc;
  assign ex_rs1        = r_ex.rs1;
  assign ex_rs2        = r_ex.rs2;
  assign ex_rd         = r_ex.rd;
  assign ex_rs1_data   = r_ex.rs1_data;
  assign ex_rs2_data   = r_ex.rs2_data;
  assign ex_imm        = r_ex.imm;
  assign ex_alu_op     = r_ex.alu_op;
  assign ex_alu_src    = r_ex.alu_src;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;
  assign ex_reg_write  = r_ex.reg_write;
  assign ex_mem_to_reg = r_ex.mem_to_reg;
  assign stall_cycles  = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes model predictions per cycle,
// monitor pops and compares stall (pre-edge) and EX state (post-edge).
module tb_id_ex_stage;

  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [3:0]  op;
    logic        alu_src, mr, mw, rw, m2r;
  } ex_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [31:0] d1, d2, imm;
    logic [3:0]  op;
    logic        alu_src, mr, mw, rw, m2r;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        flush, hold;
  } in_t;

  typedef struct {
    logic stall;
    ex_t  ex;
    int   cnt;
  } exp_t;

  logic clk, rst;
  logic id_valid, id_uses_rs1, id_uses_rs2;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic [3:0] id_alu_op;
  logic id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic wb_reg_write, flush, mem_hold;
  logic ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_alu_op;
  logic stall;
  logic [CW-1:0] stall_cycles;

  id_ex_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .mem_hold(mem_hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .stall(stall), .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  ex_t  m_ex;
  int   m_cnt;

  function automatic ex_t dut_ex();
    return {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
            ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: what the EX stage should hold after this edge, per the priority rules.
  function automatic exp_t predict(input in_t x);
    exp_t e;
    bit   reads_load_dest;
    reads_load_dest = m_ex.valid && m_ex.mr && m_ex.rd != 0 &&
                      ((x.u1 && x.rs1 == m_ex.rd) || (x.u2 && x.rs2 == m_ex.rd));
    e.cnt = m_cnt;
    if (x.hold) begin
      e.stall = 1'b1;
      e.ex    = m_ex;
    end else if (x.flush) begin
      e.stall = 1'b0;
      e.ex    = '0;
    end else if (x.valid && reads_load_dest) begin
      e.stall = 1'b1;
      e.ex    = '0;
      e.cnt   = (m_cnt < CNTMAX) ? m_cnt + 1 : CNTMAX;
    end else begin
      e.stall      = 1'b0;
      e.ex.valid   = x.valid;
      e.ex.pc      = x.pc;
      e.ex.rs1     = x.rs1;
      e.ex.rs2     = x.rs2;
      e.ex.rd      = x.rd;
      e.ex.d1      = (x.wbw && x.wbrd != 0 && x.wbrd == x.rs1) ? x.wbd : x.d1;
      e.ex.d2      = (x.wbw && x.wbrd != 0 && x.wbrd == x.rs2) ? x.wbd : x.d2;
      e.ex.imm     = x.imm;
      e.ex.op      = x.op;
      e.ex.alu_src = x.alu_src;
      e.ex.mr      = x.mr;
      e.ex.mw      = x.mw;
      e.ex.rw      = x.rw;
      e.ex.m2r     = x.m2r;
    end
    return e;
  endfunction

  task automatic drive(input in_t x);
    id_valid = x.valid; id_pc = x.pc; id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd;
    id_uses_rs1 = x.u1; id_uses_rs2 = x.u2; id_rs1_data = x.d1; id_rs2_data = x.d2;
    id_imm = x.imm; id_alu_op = x.op; id_alu_src = x.alu_src; id_mem_read = x.mr;
    id_mem_write = x.mw; id_reg_write = x.rw; id_mem_to_reg = x.m2r;
    wb_reg_write = x.wbw; wb_rd = x.wbrd; wb_data = x.wbd;
    flush = x.flush; mem_hold = x.hold;
  endtask

  task automatic apply(input in_t x);
    exp_t e;
    @(negedge clk);
    drive(x);
    e = predict(x);
    q.push_back(e);
    m_ex  = e.ex;
    m_cnt = e.cnt;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic in_t lw(input logic [4:0] rd);
    in_t x = '0;
    x.valid = 1; x.pc = 32'h200; x.rs1 = 5'd1; x.u1 = 1; x.rd = rd; x.imm = 32'h8;
    x.alu_src = 1; x.mr = 1; x.rw = 1; x.m2r = 1;
    return x;
  endfunction

  function automatic in_t add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    in_t x = '0;
    x.valid = 1; x.pc = 32'h204; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
    x.u1 = 1; x.u2 = 1; x.d1 = 32'h1111; x.d2 = 32'h2222; x.rw = 1;
    return x;
  endfunction

  function automatic in_t rnd_in();
    in_t x;
    x.valid = ($urandom_range(0, 7) != 0);
    x.pc = $urandom; x.rs1 = 5'($urandom_range(0, 7)); x.rs2 = 5'($urandom_range(0, 7));
    x.rd = 5'($urandom_range(0, 7)); x.u1 = 1'($urandom); x.u2 = 1'($urandom);
    x.d1 = $urandom; x.d2 = $urandom; x.imm = $urandom; x.op = 4'($urandom);
    x.alu_src = 1'($urandom); x.mr = ($urandom_range(0, 2) == 0); x.mw = 1'($urandom);
    x.rw = 1'($urandom); x.m2r = 1'($urandom);
    x.wbw = 1'($urandom); x.wbrd = 5'($urandom_range(0, 7)); x.wbd = $urandom;
    x.flush = ($urandom_range(0, 9) == 0); x.hold = ($urandom_range(0, 7) == 0);
    return x;
  endfunction

  // Monitor: stall sampled late in the low phase, EX state just after the edge.
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        s = stall;
        check("stall", 160'(s), 160'(e.stall));
        @(posedge clk);
        #1;
        check("ex_state", 160'(dut_ex()), 160'(e.ex));
        check("stall_cycles", 160'(stall_cycles), 160'(e.cnt));
      end
    end
  end

  initial begin
    in_t x;
    int  budget;
    rst = 1'b1;
    drive('0);
    m_ex = '0;
    m_cnt = 0;
    #7;
    check("reset_ex", 160'(dut_ex()), 160'(0));
    check("reset_cnt", 160'(stall_cycles), 160'(0));
    check("reset_stall", 160'(stall), 160'(0));
    @(negedge clk);
    rst = 1'b0;

    x = add(5'd3, 5'd1, 5'd2);
    x.pc = 32'h100;
    apply(x);
    after_edge();
    check("add_pc", 160'(ex_pc), 160'(32'h100));
    check("add_rd", 160'(ex_rd), 160'(3));
    check("add_valid_rw", 160'({ex_valid, ex_reg_write}), 160'(2'b11));

    apply(lw(5'd5));
    apply(add(5'd6, 5'd5, 5'd7));
    after_edge();
    check("hz_bubble", 160'(dut_ex()), 160'(0));
    check("hz_count", 160'(stall_cycles), 160'(1));
    apply(add(5'd6, 5'd5, 5'd7));

    apply(lw(5'd5));
    x = add(5'd6, 5'd5, 5'd7);
    x.flush = 1;
    apply(x);
    after_edge();
    check("flush_count", 160'(stall_cycles), 160'(1));

    apply(add(5'd9, 5'd1, 5'd2));
    x = rnd_in();
    x.hold = 1;
    repeat (3) apply(x);
    apply(add(5'd10, 5'd3, 5'd4));

    x = add(5'd8, 5'd4, 5'd0);
    x.d1 = 32'h11; x.wbw = 1; x.wbrd = 5'd4; x.wbd = 32'hDEADBEEF;
    apply(x);
    after_edge();
    check("bypass_rs1", 160'(ex_rs1_data), 160'(32'hDEADBEEF));
    x.wbrd = 5'd0;
    apply(x);
    after_edge();
    check("bypass_x0", 160'(ex_rs1_data), 160'(32'h11));

    repeat (400) apply(rnd_in());

    @(negedge clk);
    rst = 1'b1;
    drive('0);
    m_ex = '0;
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      apply(lw(5'd5));
      apply(add(5'd6, 5'd5, 5'd7));
    end
    after_edge();
    check("sat_count", 160'(stall_cycles), 160'(CNTMAX));

    apply(lw(5'd5));
    @(negedge clk);
    drive(add(5'd6, 5'd5, 5'd7));
    #1;
    check("pre_rst_stall", 160'(stall), 160'(1));
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_ex", 160'(dut_ex()), 160'(0));
    check("rst_async_cnt", 160'(stall_cycles), 160'(0));
    check("rst_async_stall", 160'(stall), 160'(0));
    @(negedge clk);
    drive('0);
    rst = 1'b0;
    m_ex = '0;
    m_cnt = 0;

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    after_edge();
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the RV32IF core with integrated load-use hazard detection and register-file write-through bypass. It captures decoded instructions from ID and presents `ex_rs1`/`ex_rs2`/`ex_rd`, operand data and control to the EX stage and the forwarding unit. It inserts one bubble on a load-use hazard, squashes on a branch flush, and freezes on a data-memory hold. A saturating counter records hazard stall cycles for performance analysis.

## Interface
- `CNT_W`, 16, width of the stall-cycle counter.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`  in  32  instruction PC.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register specifiers.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  instruction actually reads rs1/rs2.
- `id_rs1_data`, `id_rs2_data`  in  32 each  register-file read data.
- `id_imm`  in  32  sign-extended immediate.
- `id_alu_op`  in  4  ALU operation code.
- `id_alu_src`, `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_mem_to_reg`  in  1 each  control bits.
- `wb_reg_write`  in  1  WB stage writes the register file this cycle.
- `wb_rd`  in  5  WB destination register.
- `wb_data`  in  32  WB write data.
- `flush`  in  1  taken branch/jump resolved in EX; squash ID.
- `mem_hold`  in  1  data memory busy; freeze the pipeline.
- `ex_valid`, `ex_pc`, `ex_rs1`, `ex_rs2`, `ex_rd`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`, `ex_alu_op`, `ex_alu_src`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_mem_to_reg`  out  (widths as the id_ counterparts)  registered EX-stage fields.
- `stall`  out  1  combinational; hold PC and IF/ID this cycle.
- `stall_cycles`  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- Hazard term, combinational: `hz = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))`.
- Per-edge action, in strict priority order:
  - **Hold** (`mem_hold`): every `ex_` register keeps its value. `stall`=1. Counter unchanged.
  - **Flush** (`flush`, no hold): load a bubble. `stall`=0, even if `hz`=1, because the ID instruction is squashed. Counter unchanged.
  - **Hazard** (`hz`, neither of the above): load a bubble. `stall`=1. Counter +1, saturating at all-ones.
  - **Capture** (otherwise): load every `ex_` field from its `id_` counterpart. `ex_valid` = `id_valid`. `stall`=0.
- Bubble: all `ex_` outputs are zero, including data fields.
- Write-through bypass on capture only:
  - If `wb_reg_write & wb_rd != 0 & wb_rd == id_rs1`, then `ex_rs1_data` is loaded with `wb_data` instead of `id_rs1_data`.
  - The same rule applies independently to rs2.
- Instructions with `id_valid`=0 are captured normally and yield `ex_valid`=0. They never raise `hz`.
- `rs1`/`rs2`/`rd` equal to x0 are passed through unchanged. The x0 exclusion is done downstream by the forwarding unit.

## Timing
- Latency: `id_` fields appear on `ex_` outputs 1 cycle after capture.
- `stall` depends only on current `ex_` state and current inputs. It has no register stage.
- A load-use hazard costs exactly one stall cycle: after the bubble, `ex_mem_read`=0, so `hz` drops.
- Hazard concurrent with `mem_hold`:
  - `stall`=1 and the state is held.
  - The hazard is re-evaluated once hold is released.
  - The counter increments only on the edge where the bubble is actually inserted.
- `flush` and `mem_hold` concurrent: hold wins; the flush is not remembered. The EX-stage branch logic re-asserts `flush` after the hold.
- Reset: all `ex_` outputs = 0, `stall_cycles` = 0, asynchronously.
  - `stall` then evaluates combinationally; it is 0 unless `mem_hold`=1.
  - Reset asserted mid-stall discards the stalled instruction state.

## Test plan
- Reset, then capture `id_pc`=0x100, add x3,x1,x2 (`id_reg_write`=1) → next cycle `ex_pc`=0x100, `ex_rd`=3, `ex_reg_write`=1, `ex_valid`=1, `stall`=0.
- lw x5 captured, then ID add x6,x5,x7 (`id_uses_rs1`=1) → `stall`=1 for one cycle, then a bubble (`ex_valid`=0, all control 0), `stall_cycles`=1; the next edge captures the add.
- Same load-use pair with `flush`=1 in the hazard cycle → `stall`=0, bubble loaded, `stall_cycles` unchanged.
- `mem_hold`=1 for 3 cycles with a valid instruction in EX → `ex_` outputs constant, `stall`=1 throughout; capture resumes on the first edge after release.
- ID reads x4 (`id_rs1_data`=0x11) while `wb_reg_write`=1, `wb_rd`=4, `wb_data`=0xDEADBEEF → `ex_rs1_data`=0xDEADBEEF. With `wb_rd`=0, `ex_rs1_data`=0x11.
- `CNT_W`=4, drive 17 load-use hazards → `stall_cycles` saturates at 15; asynchronous `rst` mid-stall → all outputs 0 immediately.
